// File: rtl/pc_fetch_if.sv
// Bus between the fetch stage, instruction memory and the IF/ID pipeline register.
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output if_valid, if_instr, if_pc_plus4
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  if_valid, if_instr, if_pc_plus4
    );
endinterface

// File: rtl/pc_fetch.sv
// MIPS instruction-fetch stage: program counter, single-cycle imem fetch, IF/ID
// register with a one-entry skid buffer for downstream stalls, and redirect/flush.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    output logic [31:0]       pc_out,
    input  logic [31:0]       pc_plus4_in,
    pc_fetch_if.master        bus
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic        accept;
    logic        redirect;
    logic [31:0] target;

    assign pc_out          = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = (state_q == FETCH) && !rst;
    assign bus.if_valid    = valid_q;
    assign bus.if_instr    = instr_q;
    assign bus.if_pc_plus4 = pc4_q;

    assign accept   = !valid_q || !stall;
    assign redirect = branch_taken || jump;
    // Branch resolves in EX, so it belongs to an older instruction than an ID jump.
    assign target   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc4_q        <= 32'h0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (redirect) begin
            // Flush wins over stall; any data returned this cycle is on the wrong path.
            state_d      = FETCH;
            pc_d         = target;
            valid_d      = 1'b0;
            instr_d      = NOP_INSTR;
            skid_instr_d = NOP_INSTR;
            skid_pc4_d   = 32'h0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_ready) begin
                        pc_d = pc_plus4_in;
                        if (accept) begin
                            valid_d = 1'b1;
                            instr_d = bus.imem_rdata;
                            pc4_d   = pc_plus4_in;
                        end else begin
                            skid_instr_d = bus.imem_rdata;
                            skid_pc4_d   = pc_plus4_in;
                            state_d      = HOLD;
                        end
                    end else if (!stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_d      = 1'b1;
                        instr_d      = skid_instr_q;
                        pc4_d        = skid_pc4_q;
                        skid_instr_d = NOP_INSTR;
                        skid_pc4_d   = 32'h0;
                        state_d      = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized self-checking bench for pc_fetch against a queue-based fetch model.
module tb_pc_fetch;
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_out        (pc_out),
        .pc_plus4_in   (pc_plus4),
        .bus           (bus)
    );

    // The PC+4 adder lives outside the fetch stage.
    assign pc_plus4 = pc_out + 32'd4;

    always #5 clk = ~clk;

    int assert_count = 0;
    int fail_count   = 0;

    // Reference state: the pending skid entry is a queue of at most one {instr, pc+4}.
    logic [31:0] m_pc    = RESET_PC;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = NOP_INSTR;
    logic [31:0] m_pc4   = 32'h0;
    logic [63:0] m_skid[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic b_en, input logic [31:0] b_tgt,
                                 input logic j_en, input logic [31:0] j_tgt, input logic rdy, input logic [31:0] rd);
        logic [63:0] entry;
        @(negedge clk);
        rst                = r;
        stall              = s;
        branch_taken       = b_en;
        branch_target      = b_tgt;
        jump               = j_en;
        jump_target        = j_tgt;
        bus.imem_ready     = rdy;
        bus.imem_rdata     = rd;
        #1;
        checkOutput("pc_out",    pc_out,        m_pc);
        checkOutput("imem_addr", bus.imem_addr, m_pc);
        checkOutput("imem_req",  {31'h0, bus.imem_req}, {31'h0, !r && (m_skid.size() == 0)});
        checkOutput("if_valid",  {31'h0, bus.if_valid}, {31'h0, m_valid});
        if (m_valid) begin
            checkOutput("if_instr",    bus.if_instr,    m_instr);
            checkOutput("if_pc_plus4", bus.if_pc_plus4, m_pc4);
        end else begin
            checkOutput("if_instr_nop", bus.if_instr, NOP_INSTR);
        end

        if (r) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP_INSTR; m_pc4 = 32'h0;
            m_skid.delete();
        end else if (b_en || j_en) begin
            m_pc = (b_en ? b_tgt : j_tgt) & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_instr = NOP_INSTR;
            m_skid.delete();
        end else if (m_skid.size() == 0) begin
            if (rdy) begin
                if (!m_valid || !s) begin
                    m_valid = 1'b1; m_instr = rd; m_pc4 = m_pc + 32'd4;
                end else begin
                    m_skid.push_back({rd, m_pc + 32'd4});
                end
                m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_valid = 1'b0; m_instr = NOP_INSTR;
            end
        end else if (!s) begin
            entry   = m_skid.pop_front();
            m_valid = 1'b1;
            m_instr = entry[63:32];
            m_pc4   = entry[31:0];
        end
    endtask

    initial begin
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0;

        // Reset held for two cycles with memory ready
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hDEAD_0001);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hDEAD_0002);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1111_0000);
        @(posedge clk); #1;
        checkOutput("rst_first_pc4", bus.if_pc_plus4, 32'h0040_0004);

        // Streaming, then a three-cycle stall and release
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1111_0000 + i);
        for (int i = 0; i < 3; i++)  applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h2222_0000 + i);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h3333_0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h3333_0001);

        // Redirect under stall, then simultaneous branch and jump
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h4444_0000);
        applyStimulus(0, 1, 1, 32'h0000_0103, 0, 0, 1, 32'hBAD0_0000);
        @(posedge clk); #1;
        checkOutput("branch_pc", pc_out, 32'h0000_0100);
        checkOutput("branch_flush", {31'h0, bus.if_valid}, 32'h0);
        applyStimulus(0, 0, 1, 32'h0000_0200, 1, 32'h0000_0300, 1, 32'hBAD0_0001);
        @(posedge clk); #1;
        checkOutput("branch_wins", pc_out, 32'h0000_0200);

        // PC wrap
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h5555_0000);
        @(posedge clk); #1;
        checkOutput("wrap_pc", pc_out, 32'h0000_0000);

        // Reset while holding a skid entry
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h6666_0000);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h6666_0001);
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 32'h6666_0002);
        @(posedge clk); #1;
        checkOutput("rst_hold_valid", {31'h0, bus.if_valid}, 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h6666_0003);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, b, j, rdy;
            logic [31:0] bt, jt;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 9) < 3);
            b   = ($urandom_range(0, 19) == 0);
            j   = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            bt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            jt  = $urandom;
            applyStimulus(r, s, b, bt, j, jt, rdy, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
